// File: rtl/jtkiwi_vout.sv
// Video output stage: realigns timing to mixer colour, expands RGB555 to RGB888 with blanking, counts lines and frames; define JTKIWI_SCANLINE_EN for odd-line dimming.
// Latency: timing DLY pixel enables, colour 1 pixel enable.
// Backpressure: none; every register holds while pxl_cen is low.
module jtkiwi_vout #(
    parameter int DLY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic       HS,
    input  logic       VS,
    input  logic [4:0] red,
    input  logic [4:0] green,
    input  logic [4:0] blue,
    input  logic       scan_en,
    output logic       LHBL_dly,
    output logic       LVBL_dly,
    output logic       HS_dly,
    output logic       VS_dly,
    output logic       de,
    output logic [7:0] r8,
    output logic [7:0] g8,
    output logic [7:0] b8,
    output logic [7:0] frame_cnt,
    output logic [8:0] lines_frame
);

    typedef struct packed {
        logic lhbl;
        logic lvbl;
        logic hs;
        logic vs;
    } timing_t;

    timing_t    dly_line [DLY];
    logic       hs_prev;
    logic       vs_prev;
    logic       hs_rise;
    logic       vs_rise;
    logic       odd;
    logic [8:0] line_cnt;
    logic [7:0] r_nx;
    logic [7:0] g_nx;
    logic [7:0] b_nx;

    // Replicating the top bits makes full scale map to 255 exactly.
    function automatic logic [7:0] expand(input logic [4:0] x);
        return {x, x[4:2]};
    endfunction

`ifdef JTKIWI_SCANLINE_EN
    logic dim;

    function automatic logic [7:0] shade(input logic [7:0] v, input logic en);
        return en ? v - {2'b00, v[7:2]} : v;
    endfunction

    assign dim = scan_en & odd;
`else
    logic unused_scan;
    assign unused_scan = scan_en;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DLY; i++) dly_line[i] <= '0;
        end else if (pxl_cen) begin
            dly_line[0] <= {LHBL, LVBL, HS, VS};
            for (int i = 1; i < DLY; i++) dly_line[i] <= dly_line[i-1];
        end
    end

    assign LHBL_dly = dly_line[DLY-1].lhbl;
    assign LVBL_dly = dly_line[DLY-1].lvbl;
    assign HS_dly   = dly_line[DLY-1].hs;
    assign VS_dly   = dly_line[DLY-1].vs;
    assign de       = LHBL_dly & LVBL_dly;

    always_comb begin
        r_nx = '0;
        g_nx = '0;
        b_nx = '0;
        if (de) begin
`ifdef JTKIWI_SCANLINE_EN
            r_nx = shade(expand(red),   dim);
            g_nx = shade(expand(green), dim);
            b_nx = shade(expand(blue),  dim);
`else
            r_nx = expand(red);
            g_nx = expand(green);
            b_nx = expand(blue);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r8 <= '0;
            g8 <= '0;
            b8 <= '0;
        end else if (pxl_cen) begin
            r8 <= r_nx;
            g8 <= g_nx;
            b8 <= b_nx;
        end
    end

    assign hs_rise = HS_dly & ~hs_prev;
    assign vs_rise = VS_dly & ~vs_prev;

    // A frame boundary overrides a coincident line start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
            line_cnt    <= '0;
            odd         <= 1'b0;
            frame_cnt   <= '0;
            lines_frame <= '0;
        end else if (pxl_cen) begin
            hs_prev <= HS_dly;
            vs_prev <= VS_dly;
            if (vs_rise) begin
                lines_frame <= line_cnt;
                line_cnt    <= '0;
                odd         <= 1'b0;
                frame_cnt   <= frame_cnt + 8'd1;
            end else if (hs_rise) begin
                if (line_cnt != 9'h1FF) line_cnt <= line_cnt + 9'd1;
                odd <= ~odd;
            end
        end
    end

endmodule

// File: tb/tb_jtkiwi_vout.sv
// Bench for jtkiwi_vout: directed video scenarios plus random pixels against a pixel-history model.
module tb_jtkiwi_vout;
    localparam int DLY = 2;

`ifdef JTKIWI_SCANLINE_EN
    localparam int SCAN = 1;
`else
    localparam int SCAN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pxl_cen = 1'b0;
    logic       LHBL = 1'b1, LVBL = 1'b1, HS = 1'b0, VS = 1'b0;
    logic [4:0] red = '0, green = '0, blue = '0;
    logic       scan_en = 1'b0;
    logic       LHBL_dly, LVBL_dly, HS_dly, VS_dly, de;
    logic [7:0] r8, g8, b8, frame_cnt;
    logic [8:0] lines_frame;

    jtkiwi_vout #(.DLY(DLY)) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
        .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS),
        .red(red), .green(green), .blue(blue), .scan_en(scan_en),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .HS_dly(HS_dly), .VS_dly(VS_dly),
        .de(de), .r8(r8), .g8(g8), .b8(b8),
        .frame_cnt(frame_cnt), .lines_frame(lines_frame)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Model: history of sampled timing {LHBL,LVBL,HS,VS}, primed with DLY+1 blank pixels.
    logic [3:0] tq[$];
    int m_lc, m_odd, m_fc, m_lf, e_r, e_g, e_b, n_smp;
    int unsigned smp_cyc;
    int fr = -1, fg = -1, fb = -1;
    logic g_sc = 1'b0;
    int   sc_rnd = 0;
    int   rnd_gap = 0;

    function automatic int ext5(input int x);
        return x * 8 + x / 4;
    endfunction

    function automatic int shade(input int v, input int dim);
        return dim ? v - v / 4 : v;
    endfunction

    task automatic model_reset();
        tq.delete();
        repeat (DLY + 1) tq.push_back(4'b0000);
        m_lc = 0; m_odd = 0; m_fc = 0; m_lf = 0;
        e_r = 0; e_g = 0; e_b = 0; n_smp = 0;
    endtask

    task automatic model_step(input logic [3:0] t, input int r, input int g, input int b, input logic sc);
        logic [3:0] cur, prv;
        int dim;
        cur = tq[tq.size() - DLY];
        prv = tq[tq.size() - DLY - 1];
        dim = (SCAN == 1 && sc && m_odd == 1) ? 1 : 0;
        if (cur[3] && cur[2]) begin
            e_r = shade(ext5(r), dim); e_g = shade(ext5(g), dim); e_b = shade(ext5(b), dim);
        end else begin
            e_r = 0; e_g = 0; e_b = 0;
        end
        if (cur[0] && !prv[0]) begin
            m_lf = m_lc; m_lc = 0; m_odd = 0; m_fc = (m_fc + 1) % 256;
        end else if (cur[1] && !prv[1]) begin
            m_lc = (m_lc < 511) ? m_lc + 1 : 511;
            m_odd = 1 - m_odd;
        end
        tq.push_back(t);
        if (tq.size() > DLY + 8) void'(tq.pop_front());
        n_smp++;
    endtask

    task automatic chk_all();
        logic [3:0] t;
        t = tq[tq.size() - DLY];
        check("lhbl_dly", LHBL_dly, t[3]);
        check("lvbl_dly", LVBL_dly, t[2]);
        check("hs_dly", HS_dly, t[1]);
        check("vs_dly", VS_dly, t[0]);
        check("de", de, t[3] & t[2]);
        check("r8", r8, e_r);
        check("g8", g8, e_g);
        check("b8", b8, e_b);
        check("frame_cnt", frame_cnt, m_fc);
        check("lines_frame", lines_frame, m_lf);
    endtask

    // One pixel: sample on pxl_cen, then idle cycles with garbage inputs that must be ignored.
    task automatic pix(input logic lh, input logic lv, input logic hs, input logic vs);
        int r, g, b, gaps;
        logic sc;
        r = (fr < 0) ? int'($urandom_range(0, 31)) : fr;
        g = (fg < 0) ? int'($urandom_range(0, 31)) : fg;
        b = (fb < 0) ? int'($urandom_range(0, 31)) : fb;
        sc = (sc_rnd != 0) ? 1'($urandom_range(0, 1)) : g_sc;
        LHBL = lh; LVBL = lv; HS = hs; VS = vs;
        red = r[4:0]; green = g[4:0]; blue = b[4:0]; scan_en = sc;
        pxl_cen = 1'b1;
        @(posedge clk);
        model_step({lh, lv, hs, vs}, r, g, b, sc);
        #1;
        smp_cyc = cyc;
        chk_all();
        pxl_cen = 1'b0;
        LHBL = 1'($urandom); LVBL = 1'($urandom); HS = 1'($urandom); VS = 1'($urandom);
        red = 5'($urandom); green = 5'($urandom); blue = 5'($urandom); scan_en = 1'($urandom);
        gaps = (rnd_gap != 0) ? int'($urandom_range(1, 3)) : 1;
        repeat (gaps) @(posedge clk);
        #1;
        chk_all();
    endtask

    task automatic pulse_hs();
        pix(1, 1, 1, 0); pix(1, 1, 0, 0); pix(1, 1, 0, 0);
    endtask

    task automatic pulse_vs();
        pix(1, 1, 0, 1); pix(1, 1, 0, 0);
    endtask

    task automatic flush();
        repeat (DLY + 2) pix(1, 1, 0, 0);
    endtask

    initial begin
        int unsigned c9;
        int fc0, seen;

        model_reset();
        #12;
        chk_all();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // LHBL low at pixel 10 appears at the output during pixel 12.
        for (int i = 0; i < 10; i++) begin
            pix(1, 1, 0, 0);
            if (i == 9) c9 = smp_cyc;
        end
        pix(0, 1, 0, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            pix(1, 1, 0, 0);
            if (seen == 0 && LHBL_dly == 1'b0) begin
                seen = 1;
                check("lhbl_lat_clk", int'(smp_cyc - c9), 4);
                check("lhbl_lat_px", n_smp, 12);
            end
        end
        check("lhbl_dly_seen", seen, 1);

        // Colour expansion and blanking.
        fr = 31; fg = 16; fb = 0;
        pix(1, 1, 0, 0);
        check("exp_r8", r8, 255);
        check("exp_g8", g8, 132);
        check("exp_b8", b8, 0);
        repeat (DLY + 1) pix(0, 1, 0, 0);
        check("blank_r8", r8, 0);
        check("blank_g8", g8, 0);
        fr = -1; fg = -1; fb = -1;
        flush();

        // Full 272-line frame.
        pulse_vs(); flush();
        repeat (272) pulse_hs();
        fc0 = m_fc;
        pulse_vs(); flush();
        check("lines_272", lines_frame, 272);
        check("fc_inc", frame_cnt, (fc0 + 1) % 256);

        // 256 frames wrap the counter back.
        fc0 = m_fc;
        repeat (256) pulse_vs();
        flush();
        check("fc_wrap", frame_cnt, fc0);

        // Coincident HS/VS: VS wins, the HS line is not counted.
        repeat (5) pulse_hs();
        pix(1, 1, 1, 1); pix(1, 1, 0, 0); pix(1, 1, 0, 0);
        flush();
        check("simul_latch", lines_frame, 5);
        repeat (3) pulse_hs();
        pulse_vs(); flush();
        check("simul_lines", lines_frame, 3);

        // Saturation at 511.
        repeat (600) pulse_hs();
        pulse_vs(); flush();
        check("lines_sat", lines_frame, 511);

        // Scanline dimming on odd lines.
        fr = 31; g_sc = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            pix(1, 1, 1, 0);
            repeat (5) pix(1, 1, 0, 0);
            check("scan_r8", r8, (SCAN == 1 && (j % 2) == 1) ? 192 : 255);
        end
        fr = -1; g_sc = 1'b0;

        // Asynchronous reset mid-line with pxl_cen low.
        pulse_hs(); pulse_vs();
        pix(1, 1, 1, 0); pix(1, 1, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk_all();
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_r8", r8, 0);
        #2 rst_n = 1'b1;
        repeat (5) pulse_hs();
        pulse_vs(); flush();
        check("post_rst_lines", lines_frame, 5);
        check("post_rst_fc", frame_cnt, 1);

        // Random pixels with irregular pixel enables.
        rnd_gap = 1; sc_rnd = 1;
        for (int i = 0; i < 3000; i++) begin
            pix(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 15) != 0),
                1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 60) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
